regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 32 x 32-bit integer register file. It shares the file's single write port among NUM_REQ producers (ALU, LSU, CSR/link) by round-robin valid/ready arbitration and drives the port from registered outputs. It also keeps a per-register busy scoreboard that decode queries to stall on pending destinations. It sits between the execute/memory units and the register file.

---
 rtl/regfile_wb_scheduler_pkg.sv | 11 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 52 +++++
 rtl/regfile_wb_scheduler.sv | 131 +++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file write-back path.
package regfile_wb_scheduler_pkg;
  localparam int ADDR_W = 5;
  localparam int REG_W  = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG  = '0;
  localparam logic [REG_W-1:0]  ZERO_WORD = '0;

  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant scanning upward from ptr with wrap,
// pointer moves to the slot after the grantee whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);
  import regfile_wb_scheduler_pkg::*;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW:0]   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = DIS;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_reg} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!grant_any && req[cand[PW-1:0]]) begin
        grant_any               = EN;
        grant[cand[PW-1:0]]     = EN;
        grant_idx               = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates producers onto the single register-file write
// port through registered outputs and tracks pending destinations for decode.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*REG_W-1:0]  req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_address,
  output logic [REG_W-1:0]          write_value,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic                      flush
);
  import regfile_wb_scheduler_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREGS = 1 << ADDR_W;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [REG_W-1:0]   value_arr [NUM_REQ];
  logic [ADDR_W-1:0]  sel_addr;
  logic [REG_W-1:0]   sel_value;

  logic               write_enable_reg, write_enable_next;
  logic [ADDR_W-1:0]  write_address_reg, write_address_next;
  logic [REG_W-1:0]   write_value_reg, write_value_next;

  logic [NREGS-1:0]   busy_reg;
  logic [NREGS-1:0]   busy_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grants are suppressed while reset is held so no requester sees a phantom ready.
  assign req_ready = grant & {NUM_REQ{rst}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign value_arr[gi] = req_value[gi*REG_W +: REG_W];
    end
  endgenerate

  always_comb begin
    sel_addr  = ZERO_REG;
    sel_value = ZERO_WORD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = addr_arr[i];
        sel_value = value_arr[i];
      end
    end
  end

  always_comb begin
    write_enable_next  = DIS;
    write_address_next = write_address_reg;
    write_value_next   = write_value_reg;
    if (grant_any && (sel_addr != ZERO_REG)) begin
      write_enable_next  = EN;
      write_address_next = sel_addr;
      write_value_next   = sel_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_enable_reg  <= DIS;
      write_address_reg <= ZERO_REG;
      write_value_reg   <= ZERO_WORD;
    end else begin
      write_enable_reg  <= write_enable_next;
      write_address_reg <= write_address_next;
      write_value_reg   <= write_value_next;
    end
  end

  assign write_enable  = write_enable_reg;
  assign write_address = write_address_reg;
  assign write_value   = write_value_reg;

  // Per-register scoreboard: flush beats everything, then a new issue beats the clear.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = DIS;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit = issue_valid && (issue_rd == ADDR_W'(gi));
        assign clr_hit = write_enable_reg && (write_address_reg == ADDR_W'(gi));
        assign busy_next[gi] = flush   ? DIS :
                               set_hit ? EN  :
                               clr_hit ? DIS : busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rs1_busy = busy_reg[rs1_addr] & ~(write_enable_reg && (write_address_reg == rs1_addr));
  assign rs2_busy = busy_reg[rs2_addr] & ~(write_enable_reg && (write_address_reg == rs2_addr));
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_regfile_wb_scheduler;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            write_enable;
  logic [AW-1:0]   write_address;
  logic [DW-1:0]   write_value;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic            rs1_busy, rs2_busy;
  logic            flush;

  int checks = 0;
  int passed = 0;

  int          m_ptr;
  bit          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wv;
  bit          m_busy [32];

  regfile_wb_scheduler #(.NUM_REQ(N), .REG_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_value(req_value), .req_ready(req_ready), .write_enable(write_enable),
    .write_address(write_address), .write_value(write_value),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_value[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_wa = '0; m_wv = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
    int g;
    g = model_grant(v);
    return (g >= 0) ? N'(1 << g) : '0;
  endfunction

  function automatic bit model_busy(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a] && !(m_we && m_wa == a);
  endfunction

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    int g;
    bit nb [32];
    bit n_we;
    logic [AW-1:0] n_wa, a;
    logic [DW-1:0] n_wv;
    int n_ptr;
    g = model_grant(req_valid);
    nb = m_busy; n_we = 0; n_wa = m_wa; n_wv = m_wv; n_ptr = m_ptr;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      n_ptr = (g + 1) % N;
      if (a != 0) begin
        n_we = 1; n_wa = a; n_wv = req_value[g*DW +: DW];
      end
      $display("txn t=%0t grant req%0d addr x%0d value %08h", $time, g, a, req_value[g*DW +: DW]);
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) nb[r] = 0;
    end else begin
      if (m_we) nb[m_wa] = 0;
      if (issue_valid && issue_rd != 0) nb[issue_rd] = 1;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      m_busy = nb; m_we = n_we; m_wa = n_wa; m_wv = n_wv; m_ptr = n_ptr;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_req(0, 1, 5'd1, 32'hA); set_req(1, 1, 5'd2, 32'hB); set_req(2, 1, 5'd3, 32'hC);
    issue_valid = 1; issue_rd = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd0; flush = 0;
    repeat (2) @(posedge clk);
    #1; model_reset();
    checks++; if (write_enable !== 1'b0) $display("FAIL reset_we got %b want 0", write_enable); else passed++;
    checks++; if (write_address !== 5'd0 || write_value !== 32'd0) $display("FAIL reset_port got %0d/%h want 0/0", write_address, write_value); else passed++;
    checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready); else passed++;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL reset_rs1_busy got %b want 0", rs1_busy); else passed++;
    issue_valid = 0;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL release_first_grant got %b want 001", req_ready); else passed++;
    req_valid = '0;
    tick();
    checks++; if (write_enable !== 1'b0) $display("FAIL release_idle_we got %b want 0", write_enable); else passed++;
  endtask

  task automatic test_round_robin();
    set_req(0, 1, 5'd1, 32'hA); set_req(1, 1, 5'd2, 32'hB); set_req(2, 1, 5'd3, 32'hC);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== 3'(1 << (i % 3))) $display("FAIL rr_grant%0d got %b want %b", i, req_ready, 3'(1 << (i % 3))); else passed++;
      tick();
      checks++;
      if (write_enable !== 1'b1 || write_address !== 5'(i % 3 + 1) || write_value !== 32'(32'hA + i % 3))
        $display("FAIL rr_write%0d got we=%b x%0d=%h want we=1 x%0d=%h", i, write_enable, write_address, write_value, i % 3 + 1, 32'hA + i % 3);
      else passed++;
    end
    req_valid = '0;
    tick();
    checks++;
    if (write_enable !== 1'b0 || write_address !== 5'd1 || write_value !== 32'hA)
      $display("FAIL rr_hold got we=%b x%0d=%h want we=0 x1=0000000a", write_enable, write_address, write_value);
    else passed++;
  endtask

  task automatic test_x0_drop();
    set_req(1, 1, 5'd0, 32'hDEAD);
    #1;
    checks++; if (req_ready !== 3'b010) $display("FAIL x0_ready got %b want 010", req_ready); else passed++;
    tick();
    req_valid = '0;
    checks++; if (write_enable !== 1'b0 || write_address !== 5'd1) $display("FAIL x0_we got we=%b addr=%0d want we=0 addr=1", write_enable, write_address); else passed++;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b100) $display("FAIL x0_ptr_advance got %b want 100", req_ready); else passed++;
    req_valid = '0;
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 5'd5;
    tick();
    issue_valid = 0; rs1_addr = 5'd5;
    #1;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_busy_set got %b want 1", rs1_busy); else passed++;
    set_req(0, 1, 5'd5, 32'h55);
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL sb_ready got %b want 001", req_ready); else passed++;
    tick();
    set_req(0, 0, 5'd5, 32'h55);
    #1;
    checks++; if (write_enable !== 1'b1 || write_value !== 32'h55 || rs1_busy !== 1'b0)
      $display("FAIL sb_forward got we=%b val=%h busy=%b want 1/55/0", write_enable, write_value, rs1_busy); else passed++;
    tick();
    checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_cleared got %b want 0", rs1_busy); else passed++;
  endtask

  task automatic test_collision();
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0; rs1_addr = 5'd7;
    set_req(1, 1, 5'd7, 32'h77);
    #1;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL col_pre got %b want 1", rs1_busy); else passed++;
    tick();
    set_req(1, 0, 5'd7, 32'h77);
    issue_valid = 1; issue_rd = 5'd7;
    #1;
    checks++; if (write_enable !== 1'b1 || write_address !== 5'd7 || rs1_busy !== 1'b0)
      $display("FAIL col_write got we=%b x%0d busy=%b want 1/7/0", write_enable, write_address, rs1_busy); else passed++;
    tick();
    issue_valid = 0;
    #1;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL col_set_wins got %b want 1", rs1_busy); else passed++;
  endtask

  task automatic test_flush();
    issue_valid = 1; issue_rd = 5'd3; tick();
    issue_rd = 5'd9; tick();
    issue_rd = 5'd4; flush = 1;
    set_req(2, 1, 5'd12, 32'h1234);
    rs1_addr = 5'd3; rs2_addr = 5'd9;
    #1;
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || req_ready !== 3'b100)
      $display("FAIL flush_pre got %b/%b ready=%b want 1/1/100", rs1_busy, rs2_busy, req_ready); else passed++;
    tick();
    flush = 0; issue_valid = 0; set_req(2, 0, 5'd12, 32'h1234);
    #1;
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) $display("FAIL flush_clear got %b/%b want 0/0", rs1_busy, rs2_busy); else passed++;
    checks++; if (write_enable !== 1'b1 || write_address !== 5'd12 || write_value !== 32'h1234)
      $display("FAIL flush_inflight got we=%b x%0d=%h want 1 x12=00001234", write_enable, write_address, write_value); else passed++;
    rs1_addr = 5'd4; rs2_addr = 5'd7;
    #1;
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) $display("FAIL flush_drop_issue got %b/%b want 0/0", rs1_busy, rs2_busy); else passed++;
    tick();
  endtask

  task automatic test_mid_reset();
    set_req(0, 1, 5'd20, 32'hBEEF);
    issue_valid = 1; issue_rd = 5'd21;
    tick();
    req_valid = '0; issue_valid = 0; rs1_addr = 5'd21;
    #1;
    checks++; if (write_enable !== 1'b1 || rs1_busy !== 1'b1) $display("FAIL mrst_pre got we=%b busy=%b want 1/1", write_enable, rs1_busy); else passed++;
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (write_enable !== 1'b0 || write_address !== 5'd0 || rs1_busy !== 1'b0)
      $display("FAIL mrst_clear got we=%b addr=%0d busy=%b want 0/0/0", write_enable, write_address, rs1_busy); else passed++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] rdy;
    logic [N-1:0] exp_rdy;
    int wait_cnt [N];
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !rdy[i]) || c == 0)
          set_req(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      end
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 15) == 0);
      rs1_addr    = ($urandom_range(0, 3) == 0 && m_we) ? m_wa : 5'($urandom_range(0, 31));
      rs2_addr    = 5'($urandom_range(0, 31));
      #1;
      exp_rdy = model_ready(req_valid);
      checks++; if (req_ready !== exp_rdy) $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, exp_rdy); else passed++;
      checks++; if (write_enable !== m_we || write_address !== m_wa || write_value !== m_wv)
        $display("FAIL rnd_port c=%0d got %b x%0d=%h want %b x%0d=%h", c, write_enable, write_address, write_value, m_we, m_wa, m_wv); else passed++;
      checks++; if (rs1_busy !== model_busy(rs1_addr) || rs2_busy !== model_busy(rs2_addr))
        $display("FAIL rnd_busy c=%0d got %b/%b want %b/%b", c, rs1_busy, rs2_busy, model_busy(rs1_addr), model_busy(rs2_addr)); else passed++;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          checks++; if (wait_cnt[i] > N - 1) $display("FAIL rnd_fair req%0d waited %0d want <= %0d", i, wait_cnt[i], N - 1); else passed++;
          wait_cnt[i] = 0;
        end else if (req_valid[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
      rdy = req_ready;
      tick();
    end
    req_valid = '0; issue_valid = 0; flush = 0;
  endtask

  initial begin
    req_valid = '0; req_addr = '0; req_value = '0;
    issue_valid = 0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0; flush = 0; rst = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_x0_drop();
    test_scoreboard();
    test_collision();
    test_flush();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
